// File: rtl/conv1d_stream_feeder_pkg.sv
// Shared definitions for the 1-D conv systolic array feeder.
// Holds the feeder state encoding, the default array dimensions shared with the
// array itself, and a helper giving the number of array triggers per convolution.
package conv1d_stream_feeder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StFlush,
        StDone
    } feeder_state_e;

    localparam int unsigned DefaultDataW     = 32;
    localparam int unsigned DefaultKernelLen = 10;
    localparam int unsigned DefaultSignalLen = 10;
    localparam int unsigned DefaultIdxW      = 32;

    // One trigger per input sample plus KERNEL_LEN-1 zero flush samples, which
    // equals the number of outputs the array produces for a full convolution.
    function automatic int unsigned total_triggers(input int unsigned kernel_len,
                                                   input int unsigned signal_len);
        return signal_len + kernel_len - 1;
    endfunction

endpackage

// File: rtl/conv1d_stream_feeder_if.sv
// Bus between an upstream controller and the conv1d feeder.
// Carries control (start/busy/done), the weight stream (w_*), the sample stream
// (x_*) and the array-side outputs (sa_*).
//   master: the controller / stream sources side.
//   slave:  the feeder side.
interface conv1d_stream_feeder_if
    import conv1d_stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned IDX_W  = DefaultIdxW
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic              x_valid;
    logic [DATA_W-1:0] x_data;
    logic              x_ready;
    logic              sa_trigger;
    logic [DATA_W-1:0] sa_data;
    logic [IDX_W-1:0]  sa_wen_index;
    logic [DATA_W-1:0] sa_wvalue;

    modport master (
        output start, w_valid, w_data, x_valid, x_data,
        input  busy, done, w_ready, x_ready, sa_trigger, sa_data, sa_wen_index, sa_wvalue
    );

    modport slave (
        input  start, w_valid, w_data, x_valid, x_data,
        output busy, done, w_ready, x_ready, sa_trigger, sa_data, sa_wen_index, sa_wvalue
    );
endinterface

// File: rtl/conv1d_feed_counter.sv
// Phase counter for the conv1d feeder.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : reload the count with 0 (wins over incr)
//   incr     : advance the count by one
//   count    : current count
//   at_last  : count equals the terminal value LAST
module conv1d_feed_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAST  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             incr,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (incr) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_last = (count == WIDTH'(LAST));
endmodule

// File: rtl/conv1d_stream_feeder.sv
// Upstream sequencer for the 1-D pipelined conv systolic array.
// Per convolution: loads KERNEL_LEN weights into the PE weight registers, streams
// SIGNAL_LEN samples into the shared array lane (one trigger each), then injects
// KERNEL_LEN-1 zero flush samples and pulses done.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of conv1d_stream_feeder_if (start/busy/done, w_* and
//              x_* valid/ready streams, registered sa_* array outputs)
module conv1d_stream_feeder
    import conv1d_stream_feeder_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned KERNEL_LEN = DefaultKernelLen,
    parameter int unsigned SIGNAL_LEN = DefaultSignalLen,
    parameter int unsigned IDX_W      = DefaultIdxW
) (
    input logic                  clk,
    input logic                  rst,
    conv1d_stream_feeder_if.slave bus
);
    localparam int unsigned MAX_LEN    = (KERNEL_LEN > SIGNAL_LEN) ? KERNEL_LEN : SIGNAL_LEN;
    localparam int unsigned CNT_W      = $clog2(MAX_LEN + 1);
    // Flush runs KERNEL_LEN-1 cycles, so its last count is KERNEL_LEN-2.
    localparam int unsigned FLUSH_LAST = (KERNEL_LEN > 1) ? KERNEL_LEN - 2 : 0;

    feeder_state_e state;

    logic             w_hs, x_hs;
    logic [CNT_W-1:0] w_cnt, x_cnt, f_cnt;
    logic             w_last, x_last, f_last;

    assign bus.busy    = (state != StIdle);
    assign bus.w_ready = (state == StLoadW);
    assign bus.x_ready = (state == StStream);

    assign w_hs = bus.w_valid && bus.w_ready;
    assign x_hs = bus.x_valid && bus.x_ready;

    conv1d_feed_counter #(.WIDTH(CNT_W), .LAST(KERNEL_LEN - 1)) u_w_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == StIdle),
        .incr    (w_hs),
        .count   (w_cnt),
        .at_last (w_last)
    );

    conv1d_feed_counter #(.WIDTH(CNT_W), .LAST(SIGNAL_LEN - 1)) u_x_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == StLoadW),
        .incr    (x_hs),
        .count   (x_cnt),
        .at_last (x_last)
    );

    conv1d_feed_counter #(.WIDTH(CNT_W), .LAST(FLUSH_LAST)) u_f_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == StStream),
        .incr    (state == StFlush),
        .count   (f_cnt),
        .at_last (f_last)
    );

    // Only the weight count feeds the datapath; the others matter via at_last.
    logic unused_cnt;
    assign unused_cnt = ^{x_cnt, f_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            bus.done         <= 1'b0;
            bus.sa_trigger   <= 1'b0;
            bus.sa_data      <= '0;
            bus.sa_wen_index <= '0;
            bus.sa_wvalue    <= '0;
        end else begin
            // Pulse-type outputs default low; sa_data and sa_wvalue hold.
            bus.done         <= 1'b0;
            bus.sa_trigger   <= 1'b0;
            bus.sa_wen_index <= '0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        state <= StLoadW;
                    end
                end
                StLoadW: begin
                    if (w_hs) begin
                        bus.sa_wen_index <= IDX_W'(w_cnt) + IDX_W'(1);
                        bus.sa_wvalue    <= bus.w_data;
                        if (w_last) begin
                            state <= StStream;
                        end
                    end
                end
                StStream: begin
                    if (x_hs) begin
                        bus.sa_data    <= bus.x_data;
                        bus.sa_trigger <= 1'b1;
                        if (x_last) begin
                            state <= (KERNEL_LEN > 1) ? StFlush : StDone;
                        end
                    end
                end
                StFlush: begin
                    bus.sa_data    <= DATA_W'(0);
                    bus.sa_trigger <= 1'b1;
                    if (f_last) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    bus.done <= 1'b1;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
